// File: rtl/conv_feed_ctrl.sv
// rtl/conv_feed_ctrl.sv - streams 3-row pixel columns from the image buffer into the conv datapath
// Defining FEED_CTRL_PERF_EN adds the stall_cnt output (cycles spent waiting on col_ready).
module conv_feed_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int WIDTH      = 224,
  parameter int HEIGHT     = 224,
  parameter int SETTLE     = 5,
  parameter int ADDR_W     = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  output logic                    rd_en,
  output logic [ADDR_W-1:0]       rd_addr_top,
  output logic [ADDR_W-1:0]       rd_addr_mid,
  output logic [ADDR_W-1:0]       rd_addr_bot,
  input  logic [3*DATA_WIDTH-1:0] rd_data_top,
  input  logic [3*DATA_WIDTH-1:0] rd_data_mid,
  input  logic [3*DATA_WIDTH-1:0] rd_data_bot,
  output logic                    load_weight,
  output logic                    col_valid,
  input  logic                    col_ready,
  output logic [3*DATA_WIDTH-1:0] input_col_r,
  output logic [3*DATA_WIDTH-1:0] input_col_g,
  output logic [3*DATA_WIDTH-1:0] input_col_b,
  input  logic                    done_in,
  output logic                    busy,
`ifdef FEED_CTRL_PERF_EN
  output logic                    done,
  output logic [31:0]             stall_cnt
);
`else
  output logic                    done
);
`endif

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LOADW  = 3'd1;
  localparam logic [2:0] S_SETTLE = 3'd2;
  localparam logic [2:0] S_FEED   = 3'd3;
  localparam logic [2:0] S_DRAIN  = 3'd4;
  localparam logic [2:0] S_WAITD  = 3'd5;
  localparam logic [2:0] S_DONE   = 3'd6;

  localparam int CW = $clog2(WIDTH + 1);
  localparam int RW = $clog2(HEIGHT + 1);
  localparam int SW = $clog2(SETTLE + 2);

  logic [2:0]    state;
  logic [CW-1:0] c_cnt;
  logic [RW-1:0] r_cnt;
  logic [SW-1:0] settle_cnt;
  logic          pending;
  logic          advance;
  logic          feeding;
  logic          last_col;
  logic          start_acc;

  assign advance     = !col_valid || col_ready;
  assign feeding     = (state == S_FEED) || (state == S_DRAIN);
  assign last_col    = (r_cnt == RW'(HEIGHT - 3)) && (c_cnt == CW'(WIDTH - 1));
  assign start_acc   = (state == S_IDLE) && start;
  // FEED is left on the final read, so while in FEED a column always remains
  assign rd_en       = (state == S_FEED) && advance;
  assign load_weight = (state == S_LOADW);
  assign done        = (state == S_DONE);
  assign busy        = (state != S_IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      settle_cnt <= '0;
    end else begin
      case (state)
        S_IDLE:   if (start) state <= S_LOADW;
        S_LOADW: begin
          settle_cnt <= '0;
          state      <= (SETTLE == 0) ? S_FEED : S_SETTLE;
        end
        S_SETTLE: begin
          if (settle_cnt == SW'(SETTLE - 1)) state <= S_FEED;
          else settle_cnt <= settle_cnt + 1'b1;
        end
        S_FEED:   if (rd_en && last_col) state <= S_DRAIN;
        S_DRAIN:  if (!pending && !col_valid) state <= S_WAITD;
        S_WAITD:  if (done_in) state <= S_DONE;
        S_DONE:   state <= S_IDLE;
        default:  state <= S_IDLE;
      endcase
    end
  end

  // Rows are contiguous, so r*WIDTH+c is a plain running address; the final read holds it in range
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      c_cnt       <= '0;
      r_cnt       <= '0;
      rd_addr_top <= '0;
      rd_addr_mid <= '0;
      rd_addr_bot <= '0;
    end else if (start_acc) begin
      c_cnt       <= '0;
      r_cnt       <= '0;
      rd_addr_top <= '0;
      rd_addr_mid <= ADDR_W'(WIDTH);
      rd_addr_bot <= ADDR_W'(2 * WIDTH);
    end else if (rd_en && !last_col) begin
      rd_addr_top <= rd_addr_top + 1'b1;
      rd_addr_mid <= rd_addr_mid + 1'b1;
      rd_addr_bot <= rd_addr_bot + 1'b1;
      if (c_cnt == CW'(WIDTH - 1)) begin
        c_cnt <= '0;
        r_cnt <= r_cnt + 1'b1;
      end else begin
        c_cnt <= c_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending     <= 1'b0;
      col_valid   <= 1'b0;
      input_col_r <= '0;
      input_col_g <= '0;
      input_col_b <= '0;
    end else if (feeding && advance) begin
      if (pending) begin
        input_col_r <= {rd_data_top[3*DATA_WIDTH-1 -: DATA_WIDTH],
                        rd_data_mid[3*DATA_WIDTH-1 -: DATA_WIDTH],
                        rd_data_bot[3*DATA_WIDTH-1 -: DATA_WIDTH]};
        input_col_g <= {rd_data_top[2*DATA_WIDTH-1 -: DATA_WIDTH],
                        rd_data_mid[2*DATA_WIDTH-1 -: DATA_WIDTH],
                        rd_data_bot[2*DATA_WIDTH-1 -: DATA_WIDTH]};
        input_col_b <= {rd_data_top[DATA_WIDTH-1:0],
                        rd_data_mid[DATA_WIDTH-1:0],
                        rd_data_bot[DATA_WIDTH-1:0]};
      end
      col_valid <= pending;
      pending   <= rd_en;
    end
  end

`ifdef FEED_CTRL_PERF_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (start_acc) begin
      stall_cnt <= '0;
    end else if (col_valid && !col_ready && (stall_cnt != 32'hFFFF_FFFF)) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_conv_feed_ctrl.sv
// tb/tb_conv_feed_ctrl.sv - self-checking bench for conv_feed_ctrl (4x4 instance plus a 224x224 instance)
`timescale 1ns/1ps
module tb_conv_feed_ctrl;
  localparam int DW = 8;
  localparam int SW = 4;
  localparam int SH = 4;
  localparam int BW = 224;
  localparam int BH = 224;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [31:0] seed;
  int          checks = 0;
  int          errors = 0;

  logic        start_s, rd_en_s, load_weight_s, col_valid_s, col_ready_s, done_in_s, busy_s, done_s;
  logic [15:0] rd_addr_top_s, rd_addr_mid_s, rd_addr_bot_s;
  logic [23:0] dt_s, dm_s, db_s, input_col_r_s, input_col_g_s, input_col_b_s;
  logic        start_b, rd_en_b, load_weight_b, col_valid_b, col_ready_b, done_in_b, busy_b, done_b;
  logic [15:0] rd_addr_top_b, rd_addr_mid_b, rd_addr_bot_b;
  logic [23:0] dt_b, dm_b, db_b, input_col_r_b, input_col_g_b, input_col_b_b;
`ifdef FEED_CTRL_PERF_EN
  logic [31:0] stall_cnt_s, stall_cnt_b;
`endif

  conv_feed_ctrl #(.DATA_WIDTH(DW), .WIDTH(SW), .HEIGHT(SH), .SETTLE(2), .ADDR_W(16)) dut_s (
    .clk(clk), .rst(rst), .start(start_s), .rd_en(rd_en_s),
    .rd_addr_top(rd_addr_top_s), .rd_addr_mid(rd_addr_mid_s), .rd_addr_bot(rd_addr_bot_s),
    .rd_data_top(dt_s), .rd_data_mid(dm_s), .rd_data_bot(db_s),
    .load_weight(load_weight_s), .col_valid(col_valid_s), .col_ready(col_ready_s),
    .input_col_r(input_col_r_s), .input_col_g(input_col_g_s), .input_col_b(input_col_b_s),
    .done_in(done_in_s), .busy(busy_s),
`ifdef FEED_CTRL_PERF_EN
    .done(done_s), .stall_cnt(stall_cnt_s));
`else
    .done(done_s));
`endif

  conv_feed_ctrl #(.DATA_WIDTH(DW), .WIDTH(BW), .HEIGHT(BH), .SETTLE(5), .ADDR_W(16)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .rd_en(rd_en_b),
    .rd_addr_top(rd_addr_top_b), .rd_addr_mid(rd_addr_mid_b), .rd_addr_bot(rd_addr_bot_b),
    .rd_data_top(dt_b), .rd_data_mid(dm_b), .rd_data_bot(db_b),
    .load_weight(load_weight_b), .col_valid(col_valid_b), .col_ready(col_ready_b),
    .input_col_r(input_col_r_b), .input_col_g(input_col_g_b), .input_col_b(input_col_b_b),
    .done_in(done_in_b), .busy(busy_b),
`ifdef FEED_CTRL_PERF_EN
    .done(done_b), .stall_cnt(stall_cnt_b));
`else
    .done(done_b));
`endif

  function automatic logic [23:0] pix(input int a);
    logic [31:0] h;
    h = 32'(a) * 32'h9E3779B1 + seed;
    h = h ^ (h >> 13);
    return h[23:0];
  endfunction

  // Column k of a w-wide frame: rows r..r+2 at column c, packed as {R,G,B} lanes of {top,mid,bot}
  function automatic logic [71:0] exp_col(input int k, input int w);
    int r, c;
    logic [23:0] t, m, b;
    r = k / w;
    c = k % w;
    t = pix(r * w + c);
    m = pix((r + 1) * w + c);
    b = pix((r + 2) * w + c);
    return {t[23:16], m[23:16], b[23:16], t[15:8], m[15:8], b[15:8], t[7:0], m[7:0], b[7:0]};
  endfunction

  always @(posedge clk) begin
    if (rd_en_s) begin
      dt_s <= pix(int'(rd_addr_top_s));
      dm_s <= pix(int'(rd_addr_mid_s));
      db_s <= pix(int'(rd_addr_bot_s));
    end
    if (rd_en_b) begin
      dt_b <= pix(int'(rd_addr_top_b));
      dm_b <= pix(int'(rd_addr_mid_b));
      db_b <= pix(int'(rd_addr_bot_b));
    end
  end

  task automatic chk(input string nm, input logic [71:0] act, input logic [71:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string nm);
    chk({nm, "_ctl"}, {busy_s, done_s, load_weight_s, rd_en_s, col_valid_s}, 0);
    chk({nm, "_addr"}, {rd_addr_top_s, rd_addr_mid_s, rd_addr_bot_s}, 0);
    chk({nm, "_cols"}, {input_col_r_s, input_col_g_s, input_col_b_s}, 0);
  endtask

  typedef struct packed {
    logic       lw;
    logic       busy;
    logic       rd;
    logic       cv;
    logic       done;
    logic [7:0] addr;
    logic [7:0] col;
  } vec_t;

  // mode 0: ready=1, 1: stall 3 cycles on column 5, 2: random ready, 3: random ready + start during FEED
  task automatic run_small(input int mode, input int rst_at);
    int ncol, nrd, stalls, ndone, dly;
    logic [71:0] held, cur;
    logic was_stall, fin, got_done, pulsed;
    ncol = 0; nrd = 0; stalls = 0; ndone = 0; dly = $urandom_range(0, 4);
    was_stall = 0; fin = 0; got_done = 0; pulsed = 0; held = '0;
    done_in_s = 0; col_ready_s = 1;
    start_s = 1;
    tick();
    start_s = 0;
    for (int cyc = 0; cyc < 300; cyc++) begin
      if (got_done) begin
        chk("done_width", done_s, 0);
        chk("busy_after_done", busy_s, 0);
        fin = 1;
        break;
      end
      if (done_s) begin
        ndone++;
        got_done = 1;
      end
      cur = {input_col_r_s, input_col_g_s, input_col_b_s};
      if (rst_at >= 0 && col_valid_s && ncol == rst_at) begin
        rst = 1;
        #1;
        chk_all_zero("midframe_rst");
        tick();
        rst = 0;
        for (int k = 0; k < 3; k++) begin
          tick();
          chk("no_resume_busy", {busy_s, rd_en_s, col_valid_s}, 0);
        end
        fin = 1;
        break;
      end
      if (was_stall) begin
        chk("hold_valid", col_valid_s, 1);
        chk("hold_data", cur, held);
      end
      start_s = 0;
      if (mode == 3 && ncol == 2 && !pulsed) begin
        start_s = 1;
        pulsed = 1;
      end
      if (mode == 1) col_ready_s = !(col_valid_s && ncol == 5 && stalls < 3);
      else if (mode >= 2) col_ready_s = ($urandom_range(0, 2) != 0);
      else col_ready_s = 1;
      if (ncol == 8) begin
        if (dly == 0) done_in_s = 1;
        else dly--;
      end
      #1;
      if (rd_en_s) begin
        chk("rd_addr_top", rd_addr_top_s, (nrd / SW) * SW + nrd % SW);
        chk("rd_addr_mid", rd_addr_mid_s, (nrd / SW + 1) * SW + nrd % SW);
        chk("rd_addr_bot", rd_addr_bot_s, (nrd / SW + 2) * SW + nrd % SW);
        nrd++;
      end
      if (col_valid_s && col_ready_s) begin
        chk("col_data", cur, exp_col(ncol, SW));
        ncol++;
      end
      was_stall = col_valid_s && !col_ready_s;
      if (was_stall) begin
        stalls++;
        held = cur;
      end
      tick();
    end
    start_s = 0;
    done_in_s = 0;
    col_ready_s = 1;
    chk("frame_terminated", fin, 1);
    if (rst_at < 0) begin
      chk("col_count", ncol, 8);
      chk("read_count", nrd, 8);
      chk("done_pulses", ndone, 1);
      if (mode == 1) chk("stall_cycles", stalls, 3);
`ifdef FEED_CTRL_PERF_EN
      chk("stall_cnt", stall_cnt_s, stalls);
`endif
    end
  endtask

  task automatic run_big();
    int ncol, nrd, bad_addr, bad_data;
    logic [15:0] last_bot;
    logic got_done;
    ncol = 0; nrd = 0; bad_addr = 0; bad_data = 0; last_bot = '0; got_done = 0;
    col_ready_b = 1;
    done_in_b = 1;
    start_b = 1;
    tick();
    start_b = 0;
    for (int cyc = 0; cyc < 60000; cyc++) begin
      if (rd_en_b) begin
        if (rd_addr_top_b != 16'(nrd) || rd_addr_bot_b != 16'(nrd + 2 * BW)) bad_addr++;
        last_bot = rd_addr_bot_b;
        nrd++;
      end
      if (col_valid_b) begin
        if ({input_col_r_b, input_col_g_b, input_col_b_b} !== exp_col(ncol, BW)) bad_data++;
        ncol++;
      end
      if (done_b) begin
        got_done = 1;
        break;
      end
      tick();
    end
    done_in_b = 0;
    chk("big_done", got_done, 1);
    chk("big_col_count", ncol, (BH - 2) * BW);
    chk("big_read_count", nrd, (BH - 2) * BW);
    chk("big_last_bot", last_bot, BW * BH - 1);
    chk("big_addr_seq", bad_addr, 0);
    chk("big_col_data", bad_data, 0);
  endtask

  vec_t tbl [0:16];

  initial begin
    tbl[0]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'hFF, 8'hFF};
    tbl[1]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'hFF, 8'hFF};
    tbl[2]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'hFF, 8'hFF};
    tbl[3]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0,  8'hFF};
    tbl[4]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'd1,  8'hFF};
    tbl[5]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 8'd2,  8'd0};
    tbl[6]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 8'd3,  8'd1};
    tbl[7]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 8'd4,  8'd2};
    tbl[8]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 8'd5,  8'd3};
    tbl[9]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 8'd6,  8'd4};
    tbl[10] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 8'd7,  8'd5};
    tbl[11] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'hFF, 8'd6};
    tbl[12] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'hFF, 8'd7};
    tbl[13] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'hFF, 8'hFF};
    tbl[14] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'hFF, 8'hFF};
    tbl[15] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'hFF, 8'hFF};
    tbl[16] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'hFF, 8'hFF};

    seed = $urandom;
    rst = 1;
    start_s = 0; col_ready_s = 0; done_in_s = 0;
    start_b = 0; col_ready_b = 0; done_in_b = 0;
    repeat (2) tick();
    chk_all_zero("reset_state");
`ifdef FEED_CTRL_PERF_EN
    chk("reset_stall_cnt", stall_cnt_s, 0);
`endif
    rst = 0;
    tick();
    chk_all_zero("idle_after_reset");

    // Cycle-exact frame with col_ready=1 and done_in held high throughout
    col_ready_s = 1;
    done_in_s = 1;
    start_s = 1;
    tick();
    start_s = 0;
    for (int i = 0; i < 17; i++) begin
      chk($sformatf("tbl%0d_lw", i + 1), load_weight_s, tbl[i].lw);
      chk($sformatf("tbl%0d_busy", i + 1), busy_s, tbl[i].busy);
      chk($sformatf("tbl%0d_rd_en", i + 1), rd_en_s, tbl[i].rd);
      chk($sformatf("tbl%0d_col_valid", i + 1), col_valid_s, tbl[i].cv);
      chk($sformatf("tbl%0d_done", i + 1), done_s, tbl[i].done);
      if (tbl[i].addr != 8'hFF) begin
        chk($sformatf("tbl%0d_addr_top", i + 1), rd_addr_top_s, tbl[i].addr);
        chk($sformatf("tbl%0d_addr_bot", i + 1), rd_addr_bot_s, tbl[i].addr + 8);
      end
      if (tbl[i].col != 8'hFF)
        chk($sformatf("tbl%0d_col", i + 1), {input_col_r_s, input_col_g_s, input_col_b_s},
            exp_col(int'(tbl[i].col), SW));
      tick();
    end
    done_in_s = 0;

    run_small(1, -1);
    run_small(3, -1);
    run_small(0, 3);
    run_small(0, -1);
    for (int f = 0; f < 6; f++) begin
      seed = $urandom;
      run_small(2, -1);
    end

    seed = $urandom;
    run_big();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/conv_feed_ctrl.md
CONV_FEED_CTRL -- requirements
Module: conv_feed_ctrl

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, bits per colour sample.
REQ-002 SHALL have parameter WIDTH, default 224, image columns.
REQ-003 SHALL have parameter HEIGHT, default 224, image rows (min 3).
REQ-004 SHALL have parameter SETTLE, default 5, idle cycles between load_weight and first column.
REQ-005 SHALL have parameter ADDR_W, default 16, image buffer address width (WIDTH*HEIGHT <= 2^ADDR_W).
REQ-006 SHALL have one clock and asynchronous active-high reset: clk (input, 1) is the clock; rst (input, 1) is the reset.
REQ-007 SHALL have start (input, 1): one-cycle request to process one frame.
REQ-008 SHALL have rd_en (output, 1): read enable shared by all three image-buffer read ports.
REQ-009 SHALL have rd_addr_top, rd_addr_mid, rd_addr_bot (output, ADDR_W each): pixel addresses of rows r, r+1, r+2 at column c.
REQ-010 SHALL have rd_data_top, rd_data_mid, rd_data_bot (input, 3*DATA_WIDTH each): {R,G,B} pixel, 1-cycle latency after rd_en, held while rd_en low.
REQ-011 SHALL have load_weight (output, 1): one-cycle weight-load pulse to the conv datapath.
REQ-012 SHALL have col_valid (output, 1) and col_ready (input, 1): column handshake to the datapath.
REQ-013 SHALL have input_col_r, input_col_g, input_col_b (output, 3*DATA_WIDTH each): {top,mid,bot} samples, top in MSBs.
REQ-014 SHALL have done_in (input, 1): datapath finished (level or pulse).
REQ-015 SHALL have busy (output, 1) and done (output, 1, one-cycle pulse).

Function
REQ-016 SHALL implement states IDLE, LOADW, SETTLE, FEED, DRAIN, WAITD, DONE.
REQ-017 SHALL move IDLE->LOADW on start; start in any non-IDLE state SHALL be ignored.
REQ-018 SHALL assert load_weight exactly during LOADW (1 cycle), then enter SETTLE for exactly SETTLE cycles, then FEED.
REQ-019 SHALL in FEED scan r=0..HEIGHT-3 (outer), c=0..WIDTH-1 (inner), (HEIGHT-2)*WIDTH columns total.
REQ-020 SHALL drive rd_addr_top=r*WIDTH+c, rd_addr_mid=top+WIDTH, rd_addr_bot=top+2*WIDTH, produced by incrementing counters only (no multipliers).
REQ-021 SHALL define advance = !col_valid || col_ready; rd_en = FEED && advance && columns remain.
REQ-022 SHALL on each advance cycle: load column registers from rd_data_* if a read is pending, set col_valid = pending, set pending = rd_en.
REQ-023 SHALL hold col_valid and input_col_* stable while col_valid && !col_ready.
REQ-024 SHALL sustain one column per cycle when col_ready stays high; first col_valid 2 cycles after entering FEED.
REQ-025 SHALL enter DRAIN after the last rd_en and WAITD once pending=0 and col_valid=0.
REQ-026 SHALL leave WAITD when done_in=1 (including done_in asserted on the entry cycle), enter DONE for one cycle with done=1, then IDLE.
REQ-027 SHALL assert busy in every state except IDLE.
REQ-028 SHALL wrap c to 0 and increment r at c=WIDTH-1; no address SHALL exceed WIDTH*HEIGHT-1.

Reset
REQ-029 SHALL on rst (any time, including mid-frame) immediately go to IDLE with busy, done, load_weight, rd_en, col_valid, pending = 0, counters, addresses and input_col_* = 0.
REQ-030 SHALL need a new start after reset release; no partial-frame resume.

Configuration
REQ-031 SHALL, with FEED_CTRL_PERF_EN defined, add output stall_cnt (32 bit) counting cycles with col_valid && !col_ready, cleared by rst and on start acceptance, saturating at 2^32-1.
REQ-032 SHALL, without FEED_CTRL_PERF_EN, omit stall_cnt port and logic; all other behaviour identical.

Verification
REQ-033 SHALL cover: WIDTH=4,HEIGHT=4,SETTLE=2, col_ready=1, start -> load_weight at cycle 1, 8 columns on consecutive cycles, addresses top 0..7, bot 8..15.
REQ-034 SHALL cover: col_ready low 3 cycles at column 5 -> column 5 held stable 3 cycles, no column lost/duplicated, stall_cnt=3 (macro on).
REQ-035 SHALL cover: start pulsed during FEED -> ignored, exactly 8 columns, one done pulse.
REQ-036 SHALL cover: done_in held high before WAITD -> done one cycle after WAITD entry, busy low next cycle.
REQ-037 SHALL cover: rst at column 3 -> all outputs 0 next cycle, state IDLE; new start restarts from address 0.
REQ-038 SHALL cover: default 224x224 frame, col_ready=1 -> exactly 49728 columns, last rd_addr_bot=50175.
